// File: rtl/image_loader_pkg.sv
// Shared definitions for the image frame loader: FSM states, the sync byte
// and the frame-size legality check applied once the header is complete.
package image_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_HI   = 3'd1,
      W_LO   = 3'd2,
      H_HI   = 3'd3,
      H_LO   = 3'd4,
      CHECK  = 3'd5,
      PIXELS = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // A frame is legal when it holds at least one pixel and fits the memory.
   function automatic logic header_ok(input logic [31:0] total, input int addr_w);
      logic [63:0] limit;
      limit = 64'd1 << addr_w;
      return (total != 32'd0) && ({32'd0, total} <= limit);
   endfunction

endpackage

// File: rtl/image_loader_byte_strobe.sv
// One-byte-per-rising-edge strobe for the serial receiver's ready level, with
// a one-entry hold register for a byte that arrives while the loader is busy checking.
module byte_strobe (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   input  logic       hold,
   input  logic       flush,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   logic       rx_ready_q;
   logic       pend_valid;
   logic [7:0] pend_data;
   logic       rise;

   assign rise = rx_ready & ~rx_ready_q;

   // A held byte is replayed on the first cycle hold drops; flush discards it
   // when the frame it belonged to was rejected.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_ready_q <= 1'b0;
         pend_valid <= 1'b0;
         pend_data  <= 8'd0;
      end else begin
         rx_ready_q <= rx_ready;
         if (flush) begin
            pend_valid <= 1'b0;
         end else if (hold && rise) begin
            pend_valid <= 1'b1;
            pend_data  <= rx_data;
         end else if (!hold) begin
            pend_valid <= 1'b0;
         end
      end
   end

   assign byte_valid = ~hold & (rise | pend_valid);
   assign byte_data  = pend_valid ? pend_data : rx_data;

endmodule

// File: rtl/image_loader.sv
// Parses a framed image upload (sync, 16-bit width, 16-bit height, pixels)
// from the serial byte stream and writes pixels to memory from address 0.
module image_loader
   import image_loader_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       width,
   output logic [15:0]       height
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYC);

   state_t state, state_n;
   logic [15:0]       w_sh, h_sh, w_sh_n, h_sh_n, width_n, height_n;
   logic [ADDR_W:0]   count, count_n, total, total_n;
   logic [TW-1:0]     timer, timer_n;
   logic              we_n, done_n, error_n;
   logic [ADDR_W-1:0] addr_n;
   logic [7:0]        wdata_n;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic [31:0]       product;
   logic              header_bad;
   logic              timed_out;

   byte_strobe u_strobe (
      .clock      (clock),
      .reset      (reset),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .hold       (state == CHECK),
      .flush      ((state == CHECK) && header_bad),
      .byte_valid (byte_valid),
      .byte_data  (byte_data)
   );

   assign product    = w_sh * h_sh;
   assign header_bad = !header_ok(product, ADDR_W);
   assign busy       = (state != IDLE);
   assign timed_out  = (state != IDLE) && (state != CHECK) && !byte_valid && (timer == TIMER_LIMIT);

   always_comb begin
      state_n  = state;
      w_sh_n   = w_sh;
      h_sh_n   = h_sh;
      width_n  = width;
      height_n = height;
      count_n  = count;
      total_n  = total;
      we_n     = 1'b0;
      addr_n   = mem_addr;
      wdata_n  = mem_wdata;
      done_n   = 1'b0;
      error_n  = 1'b0;
      timer_n  = (state == IDLE || state == CHECK || byte_valid) ? '0 : timer + 1'b1;

      case (state)
         IDLE: if (byte_valid && byte_data == SYNC_BYTE) state_n = W_HI;
         W_HI: if (byte_valid) begin w_sh_n[15:8] = byte_data; state_n = W_LO; end
         W_LO: if (byte_valid) begin w_sh_n[7:0]  = byte_data; state_n = H_HI; end
         H_HI: if (byte_valid) begin h_sh_n[15:8] = byte_data; state_n = H_LO; end
         H_LO: if (byte_valid) begin h_sh_n[7:0]  = byte_data; state_n = CHECK; end
         CHECK: begin
            if (header_bad) begin
               error_n = 1'b1;
               state_n = IDLE;
            end else begin
               width_n  = w_sh;
               height_n = h_sh;
               total_n  = product[ADDR_W:0];
               count_n  = '0;
               state_n  = PIXELS;
            end
         end
         PIXELS: begin
            // Finishing one cycle after the last write puts done after mem_we.
            if (count == total) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (byte_valid) begin
               we_n    = 1'b1;
               addr_n  = count[ADDR_W-1:0];
               wdata_n = byte_data;
               count_n = count + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (timed_out) begin
         done_n  = 1'b0;
         error_n = 1'b1;
         state_n = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         w_sh      <= '0;
         h_sh      <= '0;
         width     <= '0;
         height    <= '0;
         count     <= '0;
         total     <= '0;
         timer     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         w_sh      <= w_sh_n;
         h_sh      <= h_sh_n;
         width     <= width_n;
         height    <= height_n;
         count     <= count_n;
         total     <= total_n;
         timer     <= timer_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         done      <= done_n;
         error     <= error_n;
      end
   end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: a byte-level frame parser model predicts
// writes/done/error events and a monitor compares them as the DUT emits them.
module tb_image_loader;

   localparam int ADDR_W       = 4;
   localparam int TIMEOUT_CYC  = 100;
   localparam int MAXPIX       = 1 << ADDR_W;
   localparam int K_WRITE      = 0;
   localparam int K_DONE       = 1;
   localparam int K_ERROR      = 2;
   localparam int MODE_END     = 0;
   localparam int MODE_SILENCE = 1;
   localparam int MODE_RESET   = 2;

   typedef struct {
      int kind;
      int addr;
      int data;
      int w;
      int h;
   } ev_t;

   logic              clock;
   logic              reset;
   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic              error;
   logic [15:0]       width;
   logic [15:0]       height;

   int         checks = 0;
   int         errors = 0;
   int         lastW  = 0;
   int         lastH  = 0;
   ev_t        expq[$];
   logic [7:0] txq[$];

   image_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clock     (clock),
      .reset     (reset),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .width     (width),
      .height    (height)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic string kindName(input int k);
      return (k == K_WRITE) ? "write" : (k == K_DONE) ? "done" : "error";
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic pushEv(input int kind, input int addr, input int data);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.w = lastW; e.h = lastH;
      expq.push_back(e);
   endtask

   // Reference parser: scan for sync, read header, accept or reject by pixel
   // count, then expect one write per pixel byte and a done at the end.
   task automatic buildModel(input int mode);
      int idx;
      int w, h;
      longint total;
      idx = 0;
      while (idx < txq.size()) begin
         if (txq[idx] != 8'hA5) begin
            idx++;
            continue;
         end
         if (idx + 4 >= txq.size()) begin
            if (mode == MODE_SILENCE) pushEv(K_ERROR, 0, 0);
            return;
         end
         w = {txq[idx+1], txq[idx+2]};
         h = {txq[idx+3], txq[idx+4]};
         total = longint'(w) * longint'(h);
         idx += 5;
         if (total == 0 || total > MAXPIX) begin
            pushEv(K_ERROR, 0, 0);
            continue;
         end
         lastW = w;
         lastH = h;
         for (int p = 0; p < total; p++) begin
            if (idx >= txq.size()) begin
               if (mode == MODE_SILENCE) pushEv(K_ERROR, 0, 0);
               return;
            end
            pushEv(K_WRITE, p, txq[idx]);
            idx++;
         end
         pushEv(K_DONE, 0, 0);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout actual=%0d events pending required=0", expq.size());
         expq.delete();
      end
      repeat (4) @(posedge clock);
   endtask

   task automatic applyStimulus(input int hiMin, input int hiMax, input int gapMin, input int gapMax, input int mode);
      int hi, gap;
      buildModel(mode);
      foreach (txq[i]) begin
         @(negedge clock);
         rx_data  = txq[i];
         rx_ready = 1'b1;
         hi = $urandom_range(hiMax, hiMin);
         repeat (hi) @(negedge clock);
         rx_ready = 1'b0;
         rx_data  = 8'($urandom_range(255, 0));
         gap = $urandom_range(gapMax, gapMin);
         repeat (gap - 1) @(negedge clock);
      end
      drain((mode == MODE_SILENCE) ? 400 : 100);
   endtask

   task automatic pulseReset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      lastW = 0;
      lastH = 0;
   endtask

   // Monitor: every DUT event must match the head of the expected queue.
   initial begin
      ev_t e;
      int kind;
      forever begin
         @(negedge clock);
         if (!reset && (mem_we || done || error)) begin
            checkOutput("done_error_exclusive", {31'd0, done & error}, 32'd0);
            kind = mem_we ? K_WRITE : (done ? K_DONE : K_ERROR);
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_event actual=%s addr=%0d data=%0h required=no event",
                        kindName(kind), mem_addr, mem_wdata);
            end else begin
               e = expq.pop_front();
               checks++;
               if (kind != e.kind ||
                   (kind == K_WRITE && (mem_addr !== 4'(e.addr) || mem_wdata !== 8'(e.data)))) begin
                  errors++;
                  $display("[TB] FAIL event actual=%s addr=%0d data=%0h required=%s addr=%0d data=%0h",
                           kindName(kind), mem_addr, mem_wdata, kindName(e.kind), e.addr, e.data);
               end
               checkOutput("width", {16'd0, width}, 32'(e.w));
               checkOutput("height", {16'd0, height}, 32'(e.h));
               if (kind != K_WRITE) checkOutput("busy_at_end", {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=time expired required=bench finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w, h, g;
      logic [15:0] wv, hv;
      reset    = 1'b1;
      rx_ready = 1'b0;
      rx_data  = 8'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_error", {31'd0, error}, 32'd0);
      checkOutput("reset_mem_addr", {28'd0, mem_addr}, 32'd0);
      checkOutput("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      checkOutput("reset_width", {16'd0, width}, 32'd0);
      checkOutput("reset_height", {16'd0, height}, 32'd0);

      $display("[TB] basic 2x2 frame, tightest byte spacing");
      txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(1, 1, 1, 1, MODE_END);

      $display("[TB] garbage before a 1x1 frame");
      txq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h7E};
      applyStimulus(1, 3, 1, 4, MODE_END);

      $display("[TB] rejected headers: zero pixels, too many pixels");
      txq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05};
      applyStimulus(1, 3, 1, 4, MODE_END);
      txq = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h04};
      applyStimulus(1, 3, 1, 4, MODE_END);
      txq = '{8'hA5, 8'h00, 8'h11, 8'h00, 8'h01};
      applyStimulus(1, 3, 1, 4, MODE_END);

      $display("[TB] full-memory 4x4 frame with sync bytes as pixels");
      txq = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h04};
      for (int i = 0; i < 16; i++) txq.push_back((i % 5 == 0) ? 8'hA5 : 8'(i * 17 + 3));
      applyStimulus(1, 2, 1, 3, MODE_END);

      $display("[TB] ready held high 50 cycles per byte");
      txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(50, 50, 2, 2, MODE_END);

      $display("[TB] silence after first pixel");
      txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'hAA};
      applyStimulus(1, 2, 1, 3, MODE_SILENCE);
      checkOutput("busy_after_timeout", {31'd0, busy}, 32'd0);

      $display("[TB] silence inside the header");
      txq = '{8'hA5, 8'h00};
      applyStimulus(1, 2, 1, 3, MODE_SILENCE);

      $display("[TB] reset mid-frame then a 1x1 frame");
      txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h55, 8'h66};
      applyStimulus(1, 2, 1, 3, MODE_RESET);
      pulseReset();
      checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);
      checkOutput("width_after_reset", {16'd0, width}, 32'd0);
      repeat (20) @(posedge clock);
      txq = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'hC3};
      applyStimulus(1, 2, 1, 3, MODE_END);

      $display("[TB] randomized frames");
      for (int s = 0; s < 25; s++) begin
         txq.delete();
         repeat ($urandom_range(3, 0)) begin
            g = $urandom_range(255, 0);
            if (g == 8'hA5) g = 0;
            txq.push_back(8'(g));
         end
         if ($urandom_range(3, 0) == 0) begin
            w = $urandom_range(65535, 0);
            h = $urandom_range(65535, 0);
            if (longint'(w) * longint'(h) >= 1 && longint'(w) * longint'(h) <= MAXPIX) h = 0;
         end else begin
            w = $urandom_range(16, 1);
            h = $urandom_range(16 / w, 1);
         end
         wv = w[15:0];
         hv = h[15:0];
         txq.push_back(8'hA5);
         txq.push_back(wv[15:8]);
         txq.push_back(wv[7:0]);
         txq.push_back(hv[15:8]);
         txq.push_back(hv[7:0]);
         if (longint'(w) * longint'(h) <= MAXPIX) begin
            for (int p = 0; p < w * h; p++) begin
               g = ($urandom_range(7, 0) == 0) ? 8'hA5 : $urandom_range(255, 0);
               txq.push_back(8'(g));
            end
         end
         applyStimulus(1, 5, 1, 8, MODE_END);
      end

      checkOutput("queue_empty", expq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
